// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared FSM state encoding, VGA colour constants and screen limits
package game_pkg;

    // Sprite pass sequencer states. DRAW is the reset state so the sprite
    // appears at its start position straight out of reset.
    typedef enum logic [1:0] {
        ST_DRAW  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ERASE = 2'd2,
        ST_MOVE  = 2'd3
    } state_t;

    // 3-bit RGB palette used by the VGA adapter
    localparam logic [2:0] COL_BLACK   = 3'b000;
    localparam logic [2:0] COL_BLUE    = 3'b001;
    localparam logic [2:0] COL_GREEN   = 3'b010;
    localparam logic [2:0] COL_CYAN    = 3'b011;
    localparam logic [2:0] COL_RED     = 3'b100;
    localparam logic [2:0] COL_MAGENTA = 3'b101;
    localparam logic [2:0] COL_YELLOW  = 3'b110;
    localparam logic [2:0] COL_WHITE   = 3'b111;

    // Visible frame buffer size
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider producing a one-cycle movement tick
//
// Ports:
//   CLOCK_50  in   sole clock
//   reset     in   synchronous, active-high; clears the count
//   tick      out  high for one cycle every TICK_DIV cycles
module tick_divider #(
    parameter int TICK_DIV = 833333
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - moves a rectangular sprite on a VGA frame buffer by erase/redraw passes
//
// Ports:
//   CLOCK_50                          in   sole clock
//   reset                             in   synchronous, active-high
//   mv_left, mv_right, mv_up, mv_down in   move requests, sampled once per serviced tick
//   x, y, colour, plot                out  registered VGA pixel write port
//   pos_x, pos_y                      out  current top-left corner of the sprite
//   busy                              out  high while an erase or draw pass is in progress
module sprite_mover
    import game_pkg::*;
#(
    parameter int         SPRITE_W  = 16,
    parameter int         SPRITE_H  = 8,
    parameter int         START_X   = 80,
    parameter int         START_Y   = 50,
    parameter int         X_MIN     = 10,
    parameter int         X_MAX     = 150,
    parameter int         Y_MIN     = 10,
    parameter int         Y_MAX     = 110,
    parameter int         SPEED     = 1,
    parameter int         TICK_DIV  = 833333,
    parameter logic [2:0] FG_COLOUR = COL_GREEN,
    parameter logic [2:0] BG_COLOUR = COL_BLACK
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       mv_left,
    input  logic       mv_right,
    input  logic       mv_up,
    input  logic       mv_down,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [7:0] pos_x,
    output logic [6:0] pos_y,
    output logic       busy
);

    // Legal range of the top-left corner so the whole sprite stays in bounds
    localparam logic [7:0] X_LO    = 8'(X_MIN);
    localparam logic [7:0] X_HI    = 8'(X_MAX - SPRITE_W + 1);
    localparam logic [6:0] Y_LO    = 7'(Y_MIN);
    localparam logic [6:0] Y_HI    = 7'(Y_MAX - SPRITE_H + 1);
    localparam logic [8:0] STEP    = 9'(SPEED);
    localparam logic [4:0] CX_LAST = 5'(SPRITE_W - 1);
    localparam logic [4:0] CY_LAST = 5'(SPRITE_H - 1);

    state_t     state, next_state;
    logic [4:0] cx, cy;
    logic       last_px;
    logic       tick;
    logic       pending;
    logic       load_tgt;
    logic [7:0] tgt_x, nxt_x;
    logic [6:0] tgt_y, nxt_y;
    logic [8:0] right_sum, left_diff, down_sum, up_diff;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick     (tick)
    );

    assign last_px = (cx == CX_LAST) && (cy == CY_LAST);

    // Candidate target, computed at 9 bits so a step past either edge
    // (including below zero) is caught before clamping to the bound.
    assign right_sum = {1'b0, pos_x} + STEP;
    assign left_diff = {1'b0, pos_x} - STEP;
    assign down_sum  = {2'b00, pos_y} + STEP;
    assign up_diff   = {2'b00, pos_y} - STEP;

    always_comb begin
        nxt_x = pos_x;
        if (mv_right && !mv_left) begin
            nxt_x = (right_sum > {1'b0, X_HI}) ? X_HI : right_sum[7:0];
        end else if (mv_left && !mv_right) begin
            nxt_x = (left_diff[8] || (left_diff < {1'b0, X_LO})) ? X_LO : left_diff[7:0];
        end

        nxt_y = pos_y;
        if (mv_down && !mv_up) begin
            nxt_y = (down_sum > {2'b00, Y_HI}) ? Y_HI : down_sum[6:0];
        end else if (mv_up && !mv_down) begin
            nxt_y = (up_diff[8] || (up_diff < {2'b00, Y_LO})) ? Y_LO : up_diff[6:0];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= ST_DRAW;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_tgt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    load_tgt = 1'b1;
                    if ((nxt_x != pos_x) || (nxt_y != pos_y)) begin
                        next_state = ST_ERASE;
                    end
                end
            end
            ST_ERASE: if (last_px) next_state = ST_MOVE;
            ST_MOVE:  next_state = ST_DRAW;
            ST_DRAW:  if (last_px) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cx      <= '0;
            cy      <= '0;
            pending <= 1'b0;
            tgt_x   <= 8'(START_X);
            tgt_y   <= 7'(START_Y);
            pos_x   <= 8'(START_X);
            pos_y   <= 7'(START_Y);
            plot    <= 1'b0;
            x       <= '0;
            y       <= '0;
            colour  <= BG_COLOUR;
            busy    <= 1'b1;
        end else begin
            // busy follows the state one cycle late so it lines up with plot
            busy <= (state != ST_IDLE);

            // A tick landing while a request is still pending is dropped
            if (load_tgt) begin
                pending <= 1'b0;
                tgt_x   <= nxt_x;
                tgt_y   <= nxt_y;
            end else if (tick) begin
                pending <= 1'b1;
            end

            if (state == ST_MOVE) begin
                pos_x <= tgt_x;
                pos_y <= tgt_y;
            end

            if ((state == ST_DRAW) || (state == ST_ERASE)) begin
                plot   <= 1'b1;
                x      <= pos_x + {3'b000, cx};
                y      <= pos_y + {2'b00, cy};
                colour <= (state == ST_DRAW) ? FG_COLOUR : BG_COLOUR;
                if (last_px) begin
                    cx <= '0;
                    cy <= '0;
                end else if (cx == CX_LAST) begin
                    cx <= '0;
                    cy <= cy + 5'd1;
                end else begin
                    cx <= cx + 5'd1;
                end
            end else begin
                plot <= 1'b0;
            end
        end
    end

endmodule
